maskshare_reader: RTL and testbench
===================================

# maskshare_reader

Consumer-side engine for the maskshare FIFO. It watches the FIFO's `empty` flag and head data, and pops one word at a time by pulsing the FIFO's `rd_dout` request. Each popped word is broadcast to up to NUM_DST downstream consumers, and the block holds it until every enabled consumer has acknowledged. It sits between the FIFO's storage/pointer logic and the PSU mask consumers, and drives the read port of that FIFO.

## Interface
- `DATA_BW`, 8: width of one mask word.
- `NUM_DST`, 4: number of downstream consumers.
- `CNT_BW`, 16: width of the completed-word counter.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  DATA_BW  FIFO head word, valid whenever `fifo_empty`=0.
- `rd_dout`  out  1  pop request to the FIFO; one-cycle pulse per word.
- `dst_en`  in  NUM_DST  per-consumer enable, sampled at capture.
- `dst_valid`  out  1  broadcast word valid.
- `dst_data`  out  DATA_BW  broadcast word.
- `dst_ack`  in  NUM_DST  per-consumer acknowledge; counted only while `dst_valid`=1.
- `dst_pend`  out  NUM_DST  enabled consumers not yet acknowledged for the current word.
- `share_cnt`  out  CNT_BW  number of words fully shared (or dropped) since reset; wraps.
- `busy`  out  1  high in SHARE.

## Operation
- States: IDLE, SHARE.
- **Reset** (`rst_n`=0 at an edge): go to IDLE. `dst_data`=0, `dst_pend`=0 and `share_cnt`=0. While `rst_n`=0, `rd_dout`=0, `dst_valid`=0 and `busy`=0.
- **Capture** is one cycle in which all of the following happen:
  - `rd_dout`=1 (combinational);
  - `dst_data` <= `fifo_dout`;
  - `dst_pend` <= `dst_en`.
- **IDLE:**
  - If `fifo_empty`=0, perform a capture and go to SHARE.
  - Otherwise `rd_dout`=0 and the block stays in IDLE.
- **SHARE:**
  - `dst_valid`=1. `dst_data` is held stable.
  - done = ((`dst_pend` & ~`dst_ack`) == 0).
  - If not done: `dst_pend` <= `dst_pend` & ~`dst_ack`.
  - If done: increment `share_cnt`. Then:
    - if `fifo_empty`=0, capture the next word in the same cycle and stay in SHARE (back-to-back);
    - otherwise clear `dst_pend` and go to IDLE.
- **Acks:**
  - An ack from a consumer with `dst_pend` bit 0 is ignored.
  - An ack may arrive in the first SHARE cycle.
  - Repeated acks have no effect.
- **Zero enable:** if `dst_en` is 0 at capture, the word is consumed. In the next (first SHARE) cycle `dst_valid`=1 for that one cycle, done=1 and `share_cnt` increments.
- **Counter:** `share_cnt` wraps from 2^CNT_BW−1 to 0.
- **Changing enables:** a change to `dst_en` during SHARE does not affect the current word.
- **Reset mid-SHARE:** the current word is lost (it has already been popped). There is no re-pop, and no `rd_dout` is issued in the reset cycle.
- **Pop count:** `rd_dout` is never asserted while `fifo_empty`=1, and there is exactly one pop per captured word.

## Timing
- **Latency, FIFO to consumers:** `fifo_empty` falls in cycle t (block in IDLE) → `rd_dout`=1 in cycle t → `dst_valid`=1 and `dst_data`=word from cycle t+1.
- **Minimum cycles per word:** one. If all enabled consumers ack in the first SHARE cycle and the FIFO stays non-empty, one word moves per cycle.
- **Ack to counter:** the last ack arrives in cycle s → `share_cnt` is updated at the edge ending s. If the block moves to IDLE, `dst_valid`=0 from s+1.
- **Registered outputs:** `dst_pend`, `dst_data` and `share_cnt`.
- **Combinational outputs:** `rd_dout`, `dst_valid` and `busy`, all decoded from state, `fifo_empty`, `dst_pend` and `dst_ack`.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with `fifo_empty`=0 → `rd_dout`=0 throughout; after release, `share_cnt`=0, `dst_pend`=0 and `dst_valid`=0.
- **Single word, staggered acks.** FIFO holds 0xA5, `dst_en`=4'b1011; ack bit 0 in cycle 1, bits 1 and 3 in cycle 3 → exactly one `rd_dout` pulse, `dst_data`=0xA5 for 3 cycles, `dst_pend` goes 1011 → 1010 → 0000 sequence, `share_cnt`=1, then IDLE.
- **Back-to-back.** FIFO holds 0x01, 0x02, 0x03; `dst_en`=4'hF and `dst_ack`=4'hF is held high → 3 consecutive `rd_dout` pulses, `dst_data` reads 01, 02, 03 on consecutive cycles, `share_cnt`=3.
- **Zero enable.** `dst_en`=0 with a FIFO holding 2 words → both words are popped, `share_cnt`=2, no ack is needed.
- **Reset mid-SHARE.** Word 0x3C is pending with `dst_pend`=0100; assert `rst_n`=0 for 1 cycle → IDLE, `dst_valid`=0; the next FIFO word is captured normally after release.
- **Counter wrap.** With CNT_BW=4, share 17 words → `share_cnt`=1.

Source files
------------

// File: rtl/maskshare_reader_if.sv
// Bundle between the maskshare FIFO read port, the reader engine and the PSU mask consumers.
// The reader engine takes the master view; the FIFO/consumer side takes the slave view.
interface maskshare_reader_if #(
   parameter int DATA_BW = 8,
   parameter int NUM_DST = 4,
   parameter int CNT_BW  = 16
);
   logic               fifo_empty;
   logic [DATA_BW-1:0] fifo_dout;
   logic               rd_dout;
   logic [NUM_DST-1:0] dst_en;
   logic               dst_valid;
   logic [DATA_BW-1:0] dst_data;
   logic [NUM_DST-1:0] dst_ack;
   logic [NUM_DST-1:0] dst_pend;
   logic [CNT_BW-1:0]  share_cnt;
   logic               busy;

   modport master (
      input  fifo_empty, fifo_dout, dst_en, dst_ack,
      output rd_dout, dst_valid, dst_data, dst_pend, share_cnt, busy
   );

   modport slave (
      output fifo_empty, fifo_dout, dst_en, dst_ack,
      input  rd_dout, dst_valid, dst_data, dst_pend, share_cnt, busy
   );
endinterface

// File: rtl/maskshare_reader.sv
// Pops words from the maskshare FIFO and broadcasts each one to the enabled consumers,
// holding it until every enabled consumer has acknowledged it.
module maskshare_reader #(
   parameter int DATA_BW = 8,
   parameter int NUM_DST = 4,
   parameter int CNT_BW  = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   maskshare_reader_if.master  bus
);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHARE = 1'b1;

   logic [0:0]         r_state;
   logic [DATA_BW-1:0] r_dst_data;
   logic [NUM_DST-1:0] r_dst_pend;
   logic [CNT_BW-1:0]  r_share_cnt;

   logic               w_in_share;
   logic [NUM_DST-1:0] w_pend_left;
   logic               w_done;
   logic               w_capture;

   assign w_in_share  = rst_n & (r_state == ST_SHARE);
   assign w_pend_left = r_dst_pend & ~bus.dst_ack;
   assign w_done      = (w_pend_left == '0);

   // A new word is taken from IDLE, or in the same cycle the current word completes.
   assign w_capture = rst_n & ~bus.fifo_empty & ((r_state == ST_IDLE) | w_done);

   assign bus.rd_dout   = w_capture;
   assign bus.dst_valid = w_in_share;
   assign bus.busy      = w_in_share;
   assign bus.dst_data  = r_dst_data;
   assign bus.dst_pend  = r_dst_pend;
   assign bus.share_cnt = r_share_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_dst_data  <= '0;
         r_dst_pend  <= '0;
         r_share_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_capture) begin
                  r_dst_data <= bus.fifo_dout;
                  r_dst_pend <= bus.dst_en;
                  r_state    <= ST_SHARE;
               end
            end
            ST_SHARE: begin
               if (!w_done) begin
                  r_dst_pend <= w_pend_left;
               end else begin
                  r_share_cnt <= r_share_cnt + 1'b1;
                  if (w_capture) begin
                     r_dst_data <= bus.fifo_dout;
                     r_dst_pend <= bus.dst_en;
                  end else begin
                     r_dst_pend <= '0;
                     r_state    <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_maskshare_reader.sv
// Directed bench for maskshare_reader: a small FIFO model feeds the reader and every cycle's
// outputs are compared against hand-computed values.
module tb_maskshare_reader;
   localparam int DATA_BW = 8;
   localparam int NUM_DST = 4;
   localparam int CNT_BW  = 4;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;
   int   n_fail;

   maskshare_reader_if #(.DATA_BW(DATA_BW), .NUM_DST(NUM_DST), .CNT_BW(CNT_BW)) bus ();

   maskshare_reader #(.DATA_BW(DATA_BW), .NUM_DST(NUM_DST), .CNT_BW(CNT_BW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO model: pushes come from the stimulus, pops follow rd_dout at each rising edge.
   logic [7:0] fmem [0:63];
   logic [6:0] wr_ptr;
   logic [6:0] rd_ptr;
   logic       underflow;

   assign bus.fifo_empty = (rd_ptr == wr_ptr);
   assign bus.fifo_dout  = bus.fifo_empty ? 8'h00 : fmem[rd_ptr[5:0]];

   always @(posedge clk) begin
      if (bus.rd_dout) begin
         if (bus.fifo_empty) underflow <= 1'b1;
         rd_ptr <= rd_ptr + 7'd1;
      end
   end

   task automatic push(input logic [7:0] v);
      fmem[wr_ptr[5:0]] = v;
      wr_ptr = wr_ptr + 7'd1;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Outputs forced low while reset is held.
   task automatic rchk(input string tag);
      #1;
      chk({tag, ".rd"},    32'(bus.rd_dout),   32'd0);
      chk({tag, ".valid"}, 32'(bus.dst_valid), 32'd0);
      chk({tag, ".busy"},  32'(bus.busy),      32'd0);
   endtask

   task automatic cyc(input string tag, input logic rd, input logic vld,
                      input logic [7:0] data, input logic [3:0] pend, input logic [3:0] cnt);
      #1;
      chk({tag, ".rd"},    32'(bus.rd_dout),   32'(rd));
      chk({tag, ".valid"}, 32'(bus.dst_valid), 32'(vld));
      chk({tag, ".busy"},  32'(bus.busy),      32'(vld));
      chk({tag, ".data"},  32'(bus.dst_data),  32'(data));
      chk({tag, ".pend"},  32'(bus.dst_pend),  32'(pend));
      chk({tag, ".cnt"},   32'(bus.share_cnt), 32'(cnt));
   endtask

   initial begin
      n_pass = 0; n_total = 0; n_fail = 0;
      wr_ptr = '0; rd_ptr = '0; underflow = 1'b0;
      rst_n = 1'b0;
      bus.dst_en  = 4'h0;
      bus.dst_ack = 4'h0;

      // Reset for 3 edges with a non-empty FIFO; the two words then exercise zero enable.
      push(8'h11);
      push(8'h22);
      rchk("rst0");
      next(); rchk("rst1");
      next(); rchk("rst2");
      next(); rst_n = 1'b1;
      cyc("rel", 1'b1, 1'b0, 8'h00, 4'h0, 4'd0);
      next(); cyc("ze1", 1'b1, 1'b1, 8'h11, 4'h0, 4'd0);
      next(); cyc("ze2", 1'b0, 1'b1, 8'h22, 4'h0, 4'd1);
      next(); cyc("ze3", 1'b0, 1'b0, 8'h22, 4'h0, 4'd2);
      chk("ze.pops", 32'(rd_ptr), 32'd2);

      // Single word with staggered acks, a stray ack and an enable change mid-word.
      next(); push(8'hA5); bus.dst_en = 4'b1011;
      cyc("sw0", 1'b1, 1'b0, 8'h22, 4'b0000, 4'd2);
      next(); bus.dst_ack = 4'b0001;
      cyc("sw1", 1'b0, 1'b1, 8'hA5, 4'b1011, 4'd2);
      next(); bus.dst_ack = 4'b0100; bus.dst_en = 4'b0000;
      cyc("sw2", 1'b0, 1'b1, 8'hA5, 4'b1010, 4'd2);
      next(); bus.dst_ack = 4'b1010;
      cyc("sw3", 1'b0, 1'b1, 8'hA5, 4'b1010, 4'd2);
      next(); bus.dst_ack = 4'b0000;
      cyc("sw4", 1'b0, 1'b0, 8'hA5, 4'b0000, 4'd3);
      chk("sw.pops", 32'(rd_ptr), 32'd3);

      // Back-to-back: one word per cycle with acks held high.
      next(); push(8'h01); push(8'h02); push(8'h03);
      bus.dst_en = 4'hF; bus.dst_ack = 4'hF;
      cyc("bb0", 1'b1, 1'b0, 8'hA5, 4'h0, 4'd3);
      next(); cyc("bb1", 1'b1, 1'b1, 8'h01, 4'hF, 4'd3);
      next(); cyc("bb2", 1'b1, 1'b1, 8'h02, 4'hF, 4'd4);
      next(); cyc("bb3", 1'b0, 1'b1, 8'h03, 4'hF, 4'd5);
      next(); cyc("bb4", 1'b0, 1'b0, 8'h03, 4'h0, 4'd6);
      chk("bb.pops", 32'(rd_ptr), 32'd6);

      // Reset while a word is pending: the word is lost, the next one flows normally.
      next(); bus.dst_ack = 4'h0; bus.dst_en = 4'b0100; push(8'h3C);
      cyc("mr0", 1'b1, 1'b0, 8'h03, 4'h0, 4'd6);
      next(); cyc("mr1", 1'b0, 1'b1, 8'h3C, 4'b0100, 4'd6);
      next(); rst_n = 1'b0; push(8'h5A);
      rchk("mr2");
      next(); rst_n = 1'b1;
      cyc("mr3", 1'b1, 1'b0, 8'h00, 4'h0, 4'd0);
      next(); bus.dst_ack = 4'b0100;
      cyc("mr4", 1'b0, 1'b1, 8'h5A, 4'b0100, 4'd0);
      next(); bus.dst_ack = 4'h0;
      cyc("mr5", 1'b0, 1'b0, 8'h5A, 4'h0, 4'd1);
      chk("mr.pops", 32'(rd_ptr), 32'd8);

      // Counter wrap: 17 words from a cleared counter leave it at 1.
      next(); rst_n = 1'b0;
      rchk("wr_rst");
      next(); rst_n = 1'b1; bus.dst_en = 4'hF; bus.dst_ack = 4'hF;
      for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
      cyc("wr0", 1'b1, 1'b0, 8'h00, 4'h0, 4'd0);
      for (int k = 1; k <= 17; k++) begin
         next();
         cyc($sformatf("wr%0d", k), (k < 17), 1'b1, 8'(8'h80 + k - 1), 4'hF, 4'((k - 1) % 16));
      end
      next(); cyc("wr18", 1'b0, 1'b0, 8'h90, 4'h0, 4'd1);
      chk("wr.pops", 32'(rd_ptr), 32'd25);
      chk("underflow", 32'(underflow), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
